// File: rtl/store_buffer.sv
// Store buffer: aligns byte/word (and optionally halfword) stores onto 32-bit RAM
// lanes and queues them in a DEPTH-entry FIFO drained by req/ack. Macro: STORE_HALF_EN.
module store_buffer #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        store_valid,
    output logic        store_ready,
    input  logic [31:0] store_addr,
    input  logic [31:0] store_data,
    input  logic [3:0]  store_sel,
    output logic        ram_en,
    output logic [3:0]  ram_write_en,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_write_data,
    input  logic        ram_ack,
    output logic        misalign_flag,
    output logic [31:0] misalign_addr,
    output logic        empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [3:0] {
        SEL_BYTE = 4'b0001,
        SEL_HALF = 4'b0011,
        SEL_WORD = 4'b1111
    } sel_e;

    logic [29:0]   addr_q [DEPTH];
    logic [3:0]    we_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          accept;
    logic          push;
    logic          pop;
    logic          misalign;
    logic [1:0]    offs;
    logic [3:0]    align_we;
    logic [31:0]   align_data;

    assign store_ready = (count != FULL_CNT);
    assign empty       = (count == '0);
    assign ram_en      = !empty;
    assign accept      = store_valid && store_ready;
    assign pop         = ram_en && ram_ack;
    assign offs        = store_addr[1:0];

    // Accepted stores that fail alignment or carry an unknown width code are dropped here.
    always_comb begin
        push       = 1'b0;
        misalign   = 1'b0;
        align_we   = '0;
        align_data = '0;
        case (store_sel)
            SEL_BYTE: begin
                align_we   = 4'b0001 << offs;
                align_data = {4{store_data[7:0]}};
                push       = accept;
            end
            SEL_WORD: begin
                align_we   = 4'b1111;
                align_data = store_data;
                if (offs == 2'b00) begin
                    push = accept;
                end else begin
                    misalign = accept;
                end
            end
`ifdef STORE_HALF_EN
            SEL_HALF: begin
                align_we   = offs[1] ? 4'b1100 : 4'b0011;
                align_data = {2{store_data[15:0]}};
                if (!offs[0]) begin
                    push = accept;
                end else begin
                    misalign = accept;
                end
            end
`endif
            default: begin
                push     = 1'b0;
                misalign = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= store_addr[31:2];
            we_q[wr_ptr]   <= align_we;
            data_q[wr_ptr] <= align_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            misalign_flag <= 1'b0;
            misalign_addr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            misalign_flag <= misalign;
            if (misalign) begin
                misalign_addr <= store_addr;
            end
        end
    end

    // Head fields are masked so stale FIFO contents never appear while idle.
    assign ram_addr       = ram_en ? {addr_q[rd_ptr], 2'b00} : '0;
    assign ram_write_en   = ram_en ? we_q[rd_ptr]             : '0;
    assign ram_write_data = ram_en ? data_q[rd_ptr]           : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a scoreboard of expected RAM writes is
// filled as stores are accepted and drained as the RAM acknowledges them.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        store_valid = 1'b0;
    logic        store_ready;
    logic [31:0] store_addr = '0;
    logic [31:0] store_data = '0;
    logic [3:0]  store_sel = '0;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic        ram_ack = 1'b0;
    logic        misalign_flag;
    logic [31:0] misalign_addr;
    logic        empty;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;

    store_buffer #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .store_valid(store_valid), .store_ready(store_ready),
        .store_addr(store_addr), .store_data(store_data), .store_sel(store_sel),
        .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
        .ram_write_data(ram_write_data), .ram_ack(ram_ack),
        .misalign_flag(misalign_flag), .misalign_addr(misalign_addr), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference alignment: returns 1 for an enqueued write, 2 for a misaligned reject, 0 for discard.
    function automatic int model(input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, output wr_t w);
        logic [1:0] o;
        o = a[1:0];
        w.addr = {a[31:2], 2'b00};
        w.we   = '0;
        w.data = '0;
        if (s == 4'b0001) begin
            w.we   = (o == 2'd0) ? 4'b0001 : (o == 2'd1) ? 4'b0010 :
                     (o == 2'd2) ? 4'b0100 : 4'b1000;
            w.data = {d[7:0], d[7:0], d[7:0], d[7:0]};
            return 1;
        end
        if (s == 4'b1111) begin
            w.we   = 4'b1111;
            w.data = d;
            return (o == 2'd0) ? 1 : 2;
        end
`ifdef STORE_HALF_EN
        if (s == 4'b0011) begin
            if (o == 2'd0) w.we = 4'b0011;
            else if (o == 2'd2) w.we = 4'b1100;
            w.data = {d[15:0], d[15:0]};
            return (o[0] == 1'b0) ? 1 : 2;
        end
`endif
        return 0;
    endfunction

    // Monitor: the head is compared every cycle it is presented, popped when acknowledged.
    always @(negedge clk) begin
        if (rst && ram_en) begin
            if (sb.size() == 0) begin
                check("spurious_ram_en", {31'b0, ram_en}, 32'd0);
            end else begin
                check("ram_addr", ram_addr, sb[0].addr);
                check("ram_write_en", {28'b0, ram_write_en}, {28'b0, sb[0].we});
                check("ram_write_data", ram_write_data, sb[0].data);
                if (ram_ack) void'(sb.pop_front());
            end
        end
    end

    // Drives one store, waits (bounded) for acceptance, then checks the misalign pulse.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_t w;
        int  kind;
        bit  taken;
        kind = model(a, d, s, w);
        store_valid = 1'b1;
        store_addr  = a;
        store_data  = d;
        store_sel   = s;
        taken = 0;
        for (int i = 0; i < 40 && !taken; i++) begin
            taken = store_ready;
            @(posedge clk);
            #1;
        end
        store_valid = 1'b0;
        if (!taken) begin
            check("store_accept_timeout", 32'd0, 32'd1);
        end else begin
            if (kind == 1) sb.push_back(w);
            check("misalign_flag", {31'b0, misalign_flag}, (kind == 2) ? 32'd1 : 32'd0);
            if (kind == 2) check("misalign_addr", misalign_addr, a);
        end
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 40 && !empty; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", {31'b0, empty}, 32'd1);
        check("drain_sb", sb.size(), 32'd0);
    endtask

    initial begin
        #2;
        check("rst_ready", {31'b0, store_ready}, 32'd1);
        check("rst_empty", {31'b0, empty}, 32'd1);
        check("rst_ram_en", {31'b0, ram_en}, 32'd0);
        check("rst_we", {28'b0, ram_write_en}, 32'd0);
        check("rst_addr", ram_addr, 32'd0);
        check("rst_data", ram_write_data, 32'd0);
        check("rst_mflag", {31'b0, misalign_flag}, 32'd0);
        check("rst_maddr", misalign_addr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Byte store, one-cycle latency to the RAM request.
        do_store(32'h0000_1003, 32'h0000_00A5, 4'b0001);
        check("byte_latency_ram_en", {31'b0, ram_en}, 32'd1);
        check("byte_we", {28'b0, ram_write_en}, 32'h8);
        check("byte_data", ram_write_data, 32'hA5A5_A5A5);
        ram_ack = 1'b1;
        @(posedge clk); #1;
        ram_ack = 1'b0;
        check("byte_empty", {31'b0, empty}, 32'd1);

        // Misaligned word, then back-to-back rejections.
        do_store(32'h0000_2002, 32'hDEAD_BEEF, 4'b1111);
        check("mis_empty", {31'b0, empty}, 32'd1);
        @(posedge clk); #1;
        check("mis_pulse_end", {31'b0, misalign_flag}, 32'd0);
        check("mis_hold_addr", misalign_addr, 32'h0000_2002);
        do_store(32'h0000_3001, 32'h1, 4'b1111);
        do_store(32'h0000_3003, 32'h2, 4'b1111);
        @(posedge clk); #1;
        check("mis_b2b_end", {31'b0, misalign_flag}, 32'd0);

        // Fill to DEPTH with no acks; full + ack pops without pushing.
        do_store(32'h0, 32'h1111_1111, 4'b1111);
        do_store(32'h4, 32'h2222_2222, 4'b1111);
        check("full_ready", {31'b0, store_ready}, 32'd0);
        store_valid = 1'b1;
        store_addr  = 32'h8;
        store_data  = 32'h3333_3333;
        store_sel   = 4'b1111;
        @(posedge clk); #1;
        check("full_still_blocked", {31'b0, store_ready}, 32'd0);
        ram_ack = 1'b1;
        @(posedge clk); #1;
        ram_ack = 1'b0;
        check("full_pop_no_push", {31'b0, store_ready}, 32'd1);
        sb.push_back('{addr: 32'h8, we: 4'b1111, data: 32'h3333_3333});
        @(posedge clk); #1;
        store_valid = 1'b0;
        check("full_push_next", {31'b0, store_ready}, 32'd0);
        ram_ack = 1'b1;
        wait_empty();

        // Back-to-back byte stores with ack held high.
        for (int i = 0; i < 6; i++) begin
            do_store($urandom & 32'hFFFF_FFFF, $urandom, 4'b0001);
        end
        wait_empty();

        // Undefined width codes are silently dropped.
        do_store(32'h40, 32'h5, 4'b0101);
        do_store(32'h44, 32'h6, 4'b0000);
        check("undef_empty", {31'b0, empty}, 32'd1);

`ifdef STORE_HALF_EN
        ram_ack = 1'b0;
        do_store(32'h12, 32'h0000_1234, 4'b0011);
        check("half_we", {28'b0, ram_write_en}, 32'hC);
        check("half_data", ram_write_data, 32'h1234_1234);
        ram_ack = 1'b1;
        wait_empty();
        do_store(32'h20, 32'h0000_ABCD, 4'b0011);
        do_store(32'h13, 32'h0000_1234, 4'b0011);
        wait_empty();
`else
        do_store(32'h12, 32'h0000_1234, 4'b0011);
        check("half_off_empty", {31'b0, empty}, 32'd1);
`endif

        // Asynchronous reset with two entries pending.
        ram_ack = 1'b0;
        do_store(32'h100, 32'hCAFE_0001, 4'b1111);
        do_store(32'h104, 32'hCAFE_0002, 4'b1111);
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        check("arst_ram_en", {31'b0, ram_en}, 32'd0);
        check("arst_empty", {31'b0, empty}, 32'd1);
        check("arst_ready", {31'b0, store_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        ram_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_idle", {31'b0, ram_en}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
